// File: rtl/niosii_ms2hw_nios_proc_cpu_debug_ocimem_ctrl.sv
// Debug monitor-memory controller: runs JTAG ocimem read/write commands against the debug RAM.
// Optional build macro OCIMEM_TIMEOUT_EN aborts requests stalled for TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps
module niosii_ms2hw_nios_proc_cpu_debug_ocimem_ctrl #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic              ram_waitrequest
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD      = 2'd1;
   localparam logic [1:0] S_RD_DATA = 2'd2;
   localparam logic [1:0] S_WR      = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       mon_q, mon_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              rdy_q, rdy_d;
   logic              any_cmd;
   logic              unused_jdo;

`ifdef OCIMEM_TIMEOUT_EN
   localparam int CNT_W = 10;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   assign any_cmd    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign unused_jdo = ^{jdo[37:36], jdo[34:32]};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mon_d   = mon_q;
      wdata_d = wdata_q;
      err_d   = err_q;
`ifdef OCIMEM_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (take_action_ocimem_b) begin
               wdata_d = jdo[31:0];
               state_d = S_WR;
            end else if (take_action_ocimem_a) begin
               addr_d = jdo[ADDR_W-1:0];
               err_d  = 1'b0;
               if (jdo[35]) state_d = S_RD;
            end else if (take_no_action_ocimem_a) begin
               state_d = S_RD;
            end
         end
         S_RD, S_WR: begin
            if (!ram_waitrequest) begin
               addr_d  = addr_q + 1'b1;
               state_d = (state_q == S_RD) ? S_RD_DATA : S_IDLE;
`ifdef OCIMEM_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // give up: drop the request without touching addr or MonDReg
               state_d = S_IDLE;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            mon_d   = ram_rdata;
            state_d = S_IDLE;
         end
      endcase
      // commands arriving while busy are dropped but flagged
      if (state_q != S_IDLE && any_cmd) err_d = 1'b1;
      rd_d  = (state_d == S_RD);
      wr_d  = (state_d == S_WR);
      rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         mon_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b1;
`ifdef OCIMEM_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         mon_q   <= mon_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
`ifdef OCIMEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign MonDReg       = mon_q;
   assign monitor_ready = rdy_q;
   assign monitor_error = err_q;
   assign ram_addr      = addr_q;
   assign ram_rd        = rd_q;
   assign ram_wr        = wr_q;
   assign ram_wdata     = wdata_q;

endmodule
